// File: rtl/flash_ctrl_pkg.sv
// Shared types, geometry and info-page privilege masking for the flash controller.
// info_cfg_mask() is the single definition of seed/isolation masking for all users.
package flash_ctrl_pkg;

  localparam int NumBanks       = 2;
  localparam int NumInfoTypes   = 3;
  localparam int InfosPerBank   = 10;
  localparam int BankW          = (NumBanks > 1) ? $clog2(NumBanks) : 1;
  localparam int InfoTypesWidth = (NumInfoTypes > 1) ? $clog2(NumInfoTypes) : 1;
  localparam int PageW          = (InfosPerBank > 1) ? $clog2(InfosPerBank) : 1;

  localparam int SeedBank    = 0;
  localparam int SeedInfoSel = 0;

  // Valid pages per info type; never larger than InfosPerBank.
  localparam int InfoTypeSize [NumInfoTypes] = '{10, 1, 2};

  localparam int NumSeeds       = 2;
  localparam int CreatorSeedIdx = 0;
  localparam int OwnerSeedIdx   = 1;
  localparam int SeedInfoPageSel [NumSeeds] = '{1, 2};
  localparam int IsolatedPageSel = 3;

  typedef enum logic [1:0] {
    FlashOpRead    = 2'd0,
    FlashOpProgram = 2'd1,
    FlashOpErase   = 2'd2
  } flash_op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLookup = 2'd1,
    StResp   = 2'd2
  } chk_state_e;

  typedef struct packed {
    logic [BankW-1:0]          bank;
    logic [InfoTypesWidth-1:0] sel;
    logic [PageW-1:0]          page;
  } page_addr_t;

  typedef struct packed {
    logic en;
    logic rd_en;
    logic prog_en;
    logic erase_en;
    logic scramble_en;
    logic ecc_en;
    logic he_en;
  } info_page_cfg_t;

  typedef struct packed {
    logic creator_seed;
    logic owner_seed;
    logic iso_rd;
    logic iso_wr;
  } info_privs_t;

  function automatic logic page_in_range(page_addr_t addr);
    logic ok;
    ok = (int'(addr.bank) < NumBanks) && (int'(addr.sel) < NumInfoTypes);
    // The size lookup is only meaningful once sel is known to be valid.
    if (ok) ok = int'(addr.page) < InfoTypeSize[addr.sel];
    return ok;
  endfunction

  function automatic logic is_page(page_addr_t addr, int bank, int sel, int page);
    return (int'(addr.bank) == bank) && (int'(addr.sel) == sel) && (int'(addr.page) == page);
  endfunction

  function automatic info_page_cfg_t info_cfg_mask(info_page_cfg_t cfg, page_addr_t addr,
                                                   info_privs_t privs);
    info_page_cfg_t mask;
    mask = '1;
    if (!page_in_range(addr)) begin
      mask = '0;
    end else if (is_page(addr, SeedBank, SeedInfoSel, SeedInfoPageSel[CreatorSeedIdx])) begin
      mask = info_page_cfg_t'({$bits(info_page_cfg_t){privs.creator_seed}});
    end else if (is_page(addr, SeedBank, SeedInfoSel, SeedInfoPageSel[OwnerSeedIdx])) begin
      mask = info_page_cfg_t'({$bits(info_page_cfg_t){privs.owner_seed}});
    end else if (is_page(addr, SeedBank, SeedInfoSel, IsolatedPageSel)) begin
      mask = '{en: 1'b1, rd_en: privs.iso_rd, prog_en: privs.iso_wr, erase_en: privs.iso_wr,
               scramble_en: 1'b1, ecc_en: 1'b1, he_en: 1'b1};
    end
    return cfg & mask;
  endfunction

  function automatic logic op_allowed(info_page_cfg_t cfg, flash_op_e op);
    return cfg.en && ((op == FlashOpRead)    ? cfg.rd_en :
                      (op == FlashOpProgram) ? cfg.prog_en : cfg.erase_en);
  endfunction

endpackage

// File: rtl/flash_ctrl_info_priv_chk_if.sv
// Lookup handshake between a requester (master) and the info-page privilege checker (slave).
interface flash_ctrl_info_priv_chk_if;
  import flash_ctrl_pkg::*;

  logic           req;
  page_addr_t     req_addr;
  flash_op_e      req_op;
  logic           gnt;
  logic           rsp_valid;
  logic           rsp_allow;
  logic           rsp_err;
  info_page_cfg_t rsp_cfg;

  modport master (
    output req, req_addr, req_op,
    input  gnt, rsp_valid, rsp_allow, rsp_err, rsp_cfg
  );

  modport slave (
    input  req, req_addr, req_op,
    output gnt, rsp_valid, rsp_allow, rsp_err, rsp_cfg
  );
endinterface

// File: rtl/flash_ctrl_sticky_priv.sv
// Revocable privilege: follows its input until first seen high, then can only fall,
// and stays low until reset.
module flash_ctrl_sticky_priv (
  input  logic clk_i,
  input  logic rst_i,
  input  logic priv_i,
  output logic priv_o
);

  logic armed_q;
  logic priv_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      armed_q <= 1'b0;
      priv_q  <= 1'b0;
    end else if (!armed_q) begin
      armed_q <= priv_i;
      priv_q  <= priv_i;
    end else begin
      priv_q  <= priv_q & priv_i;
    end
  end

  assign priv_o = priv_q;

endmodule

// File: rtl/flash_ctrl_info_priv_chk.sv
// Registered info-page config table with lock bits and a req/gnt/rsp privilege lookup
// returning the masked page config and an allow/deny verdict two cycles after grant.
module flash_ctrl_info_priv_chk
  import flash_ctrl_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cfg_we_i,
  input  logic                      cfg_lock_i,
  input  page_addr_t                cfg_addr_i,
  input  info_page_cfg_t            cfg_wdata_i,
  output logic                      cfg_wr_err_o,
  input  logic                      creator_seed_priv_i,
  input  logic                      owner_seed_priv_i,
  input  logic                      iso_flash_rd_en_i,
  input  logic                      iso_flash_wr_en_i,
  flash_ctrl_info_priv_chk_if.slave bus
);

  info_page_cfg_t cfg_q  [NumBanks][NumInfoTypes][InfosPerBank];
  logic           lock_q [NumBanks][NumInfoTypes][InfosPerBank];
  logic           cfg_wr_err_q;
  logic           wr_in_range;
  logic           wr_ok;

  info_privs_t    privs;

  chk_state_e     state_q, state_d;
  page_addr_t     req_addr_q;
  flash_op_e      req_op_q;
  logic           lkp_in_range;
  info_page_cfg_t lkp_raw;
  info_page_cfg_t lkp_masked;
  logic           rsp_allow_q;
  logic           rsp_err_q;
  info_page_cfg_t rsp_cfg_q;

  flash_ctrl_sticky_priv u_creator_priv (
    .clk_i, .rst_i, .priv_i(creator_seed_priv_i), .priv_o(privs.creator_seed));
  flash_ctrl_sticky_priv u_owner_priv (
    .clk_i, .rst_i, .priv_i(owner_seed_priv_i),   .priv_o(privs.owner_seed));
  flash_ctrl_sticky_priv u_iso_rd_priv (
    .clk_i, .rst_i, .priv_i(iso_flash_rd_en_i),   .priv_o(privs.iso_rd));
  flash_ctrl_sticky_priv u_iso_wr_priv (
    .clk_i, .rst_i, .priv_i(iso_flash_wr_en_i),   .priv_o(privs.iso_wr));

  assign wr_in_range = page_in_range(cfg_addr_i);
  assign wr_ok = cfg_we_i && wr_in_range &&
                 !lock_q[cfg_addr_i.bank][cfg_addr_i.sel][cfg_addr_i.page];

  // NOTE: the table is small flop storage and must read '0 after reset, so every entry is reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NumBanks; b++) begin
        for (int s = 0; s < NumInfoTypes; s++) begin
          for (int p = 0; p < InfosPerBank; p++) begin
            cfg_q[b][s][p]  <= '0;
            lock_q[b][s][p] <= 1'b0;
          end
        end
      end
      cfg_wr_err_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        cfg_q[cfg_addr_i.bank][cfg_addr_i.sel][cfg_addr_i.page] <= cfg_wdata_i;
        if (cfg_lock_i) lock_q[cfg_addr_i.bank][cfg_addr_i.sel][cfg_addr_i.page] <= 1'b1;
      end
      cfg_wr_err_q <= cfg_we_i && !wr_ok;
    end
  end

  assign cfg_wr_err_o = cfg_wr_err_q;

  // Table read happens in LOOKUP, before any same-cycle write lands at the edge.
  assign lkp_in_range = page_in_range(req_addr_q);
  assign lkp_raw      = lkp_in_range ? cfg_q[req_addr_q.bank][req_addr_q.sel][req_addr_q.page]
                                     : '0;
  assign lkp_masked   = info_cfg_mask(lkp_raw, req_addr_q, privs);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      req_addr_q  <= '0;
      req_op_q    <= FlashOpRead;
      rsp_allow_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && bus.req) begin
        req_addr_q <= bus.req_addr;
        req_op_q   <= bus.req_op;
      end
      if (state_q == StLookup) begin
        rsp_allow_q <= lkp_in_range && op_allowed(lkp_masked, req_op_q);
        rsp_err_q   <= !lkp_in_range;
        rsp_cfg_q   <= lkp_masked;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    bus.gnt       = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_allow = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.rsp_cfg   = '0;
    unique case (state_q)
      StIdle: begin
        bus.gnt = bus.req;
        if (bus.req) state_d = StLookup;
      end
      StLookup: state_d = StResp;
      StResp: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_allow = rsp_allow_q;
        bus.rsp_err   = rsp_err_q;
        bus.rsp_cfg   = rsp_cfg_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_flash_ctrl_info_priv_chk.sv
// Directed bench for flash_ctrl_info_priv_chk: config writes, locks, sticky privileges,
// masking, range errors, lookup latency and reset behaviour.
module tb_flash_ctrl_info_priv_chk;
  import flash_ctrl_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_we;
  logic           cfg_lock;
  page_addr_t     cfg_addr;
  info_page_cfg_t cfg_wdata;
  logic           cfg_wr_err;
  logic           creator_priv;
  logic           owner_priv;
  logic           iso_rd;
  logic           iso_wr;

  int n_checks = 0;
  int n_errors = 0;

  localparam info_page_cfg_t AllOnes = 7'h7f;
  localparam info_page_cfg_t IsoRdOnly = 7'h67; // en rd_en - - scr ecc he
  localparam info_page_cfg_t NoProg = 7'h6f;    // prog_en cleared

  always #5 clk = ~clk;

  flash_ctrl_info_priv_chk_if bus ();

  flash_ctrl_info_priv_chk dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .cfg_we_i            (cfg_we),
    .cfg_lock_i          (cfg_lock),
    .cfg_addr_i          (cfg_addr),
    .cfg_wdata_i         (cfg_wdata),
    .cfg_wr_err_o        (cfg_wr_err),
    .creator_seed_priv_i (creator_priv),
    .owner_seed_priv_i   (owner_priv),
    .iso_flash_rd_en_i   (iso_rd),
    .iso_flash_wr_en_i   (iso_wr),
    .bus                 (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic page_addr_t mk_addr(input int b, input int s, input int p);
    page_addr_t a;
    a.bank = BankW'(b);
    a.sel  = InfoTypesWidth'(s);
    a.page = PageW'(p);
    return a;
  endfunction

  task automatic cfg_write(input string tag, input page_addr_t a, input info_page_cfg_t d,
                           input logic lock, input logic exp_err);
    @(negedge clk);
    cfg_we = 1'b1; cfg_lock = lock; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0; cfg_lock = 1'b0;
    check({tag, "_wr_err"}, 32'(cfg_wr_err), 32'(exp_err));
    if (exp_err) begin
      @(negedge clk);
      check({tag, "_wr_err_pulse"}, 32'(cfg_wr_err), 32'd0);
    end
  endtask

  // Request at a negedge, expect grant at once, response exactly two cycles later.
  task automatic lookup(input string tag, input page_addr_t a, input flash_op_e op,
                        input logic exp_allow, input logic exp_err, input info_page_cfg_t exp_cfg);
    int waited;
    @(negedge clk);
    bus.req = 1'b1; bus.req_addr = a; bus.req_op = op;
    #1;
    waited = 0;
    while (!bus.gnt && waited < 8) begin
      @(negedge clk); #1;
      waited++;
    end
    check({tag, "_gnt"}, 32'(bus.gnt), 32'd1);
    @(negedge clk);
    bus.req = 1'b0;
    check({tag, "_valid_early"}, 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_allow"}, 32'(bus.rsp_allow), 32'(exp_allow));
    check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    check({tag, "_cfg"}, 32'(bus.rsp_cfg), 32'(exp_cfg));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    page_addr_t a3, a7;
    a3 = mk_addr(0, 0, 3);
    a7 = mk_addr(1, 0, 7);
    rst = 1'b1; cfg_we = 1'b0; cfg_lock = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    creator_priv = 1'b0; owner_priv = 1'b1; iso_rd = 1'b1; iso_wr = 1'b1;
    bus.req = 1'b0; bus.req_addr = '0; bus.req_op = FlashOpRead;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_allow", 32'(bus.rsp_allow), 32'd0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    check("rst_cfg", 32'(bus.rsp_cfg), 32'd0);
    check("rst_wr_err", 32'(cfg_wr_err), 32'd0);

    // Basic write and read of page 3 (isolated page, both iso privileges held).
    cfg_write("w_p3", a3, AllOnes, 1'b0, 1'b0);
    lookup("rd_p3", a3, FlashOpRead, 1'b1, 1'b0, AllOnes);

    // Lock, then a rejected overwrite.
    cfg_write("lock_p3", a3, AllOnes, 1'b1, 1'b0);
    cfg_write("wlocked_p3", a3, '0, 1'b0, 1'b1);
    lookup("rd_locked_p3", a3, FlashOpRead, 1'b1, 1'b0, AllOnes);

    // Creator privilege 1 -> 0 -> 1 stays revoked.
    @(negedge clk); creator_priv = 1'b1;
    @(negedge clk); creator_priv = 1'b0;
    @(negedge clk); creator_priv = 1'b1;
    @(negedge clk);
    cfg_write("w_creator", mk_addr(0, 0, 1), AllOnes, 1'b0, 1'b0);
    lookup("creator_rd", mk_addr(0, 0, 1), FlashOpRead,    1'b0, 1'b0, '0);
    lookup("creator_pg", mk_addr(0, 0, 1), FlashOpProgram, 1'b0, 1'b0, '0);
    lookup("creator_er", mk_addr(0, 0, 1), FlashOpErase,   1'b0, 1'b0, '0);

    // Owner privilege held since reset: page passes through.
    cfg_write("w_owner", mk_addr(0, 0, 2), AllOnes, 1'b0, 1'b0);
    lookup("owner_er", mk_addr(0, 0, 2), FlashOpErase, 1'b1, 1'b0, AllOnes);

    // Revoke isolated write privilege.
    @(negedge clk); iso_wr = 1'b0;
    @(negedge clk);
    lookup("iso_rd", a3, FlashOpRead,    1'b1, 1'b0, IsoRdOnly);
    lookup("iso_pg", a3, FlashOpProgram, 1'b0, 1'b0, IsoRdOnly);
    lookup("iso_er", a3, FlashOpErase,   1'b0, 1'b0, IsoRdOnly);
    @(negedge clk); iso_wr = 1'b1;
    @(negedge clk);
    lookup("iso_pg_sticky", a3, FlashOpProgram, 1'b0, 1'b0, IsoRdOnly);

    // Ordinary page verdict by op.
    cfg_write("w_noprog", mk_addr(1, 0, 5), NoProg, 1'b0, 1'b0);
    lookup("noprog_rd", mk_addr(1, 0, 5), FlashOpRead,    1'b1, 1'b0, NoProg);
    lookup("noprog_pg", mk_addr(1, 0, 5), FlashOpProgram, 1'b0, 1'b0, NoProg);

    // Range boundaries.
    cfg_write("w_last_s2", mk_addr(1, 2, 1), AllOnes, 1'b0, 1'b0);
    lookup("last_s2", mk_addr(1, 2, 1), FlashOpProgram, 1'b1, 1'b0, AllOnes);
    lookup("oor_s1", mk_addr(0, 1, 1), FlashOpRead, 1'b0, 1'b1, '0);
    lookup("oor_s2", mk_addr(1, 2, 2), FlashOpRead, 1'b0, 1'b1, '0);
    lookup("oor_s0", mk_addr(0, 0, 10), FlashOpRead, 1'b0, 1'b1, '0);
    lookup("oor_sel3", mk_addr(0, 3, 0), FlashOpRead, 1'b0, 1'b1, '0);
    cfg_write("w_oor_s1", mk_addr(0, 1, 1), AllOnes, 1'b0, 1'b1);

    // Write during LOOKUP to the page being looked up.
    @(negedge clk);
    bus.req = 1'b1; bus.req_addr = a7; bus.req_op = FlashOpRead;
    #1 check("same_gnt", 32'(bus.gnt), 32'd1);
    @(negedge clk);
    bus.req = 1'b0;
    cfg_we = 1'b1; cfg_addr = a7; cfg_wdata = AllOnes;
    @(negedge clk);
    cfg_we = 1'b0;
    check("same_valid", 32'(bus.rsp_valid), 32'd1);
    check("same_cfg", 32'(bus.rsp_cfg), 32'd0);
    check("same_allow", 32'(bus.rsp_allow), 32'd0);
    check("same_wr_err", 32'(cfg_wr_err), 32'd0);
    lookup("after_same", a7, FlashOpRead, 1'b1, 1'b0, AllOnes);

    // Request held across RESP is granted again in the following IDLE cycle.
    @(negedge clk);
    bus.req = 1'b1; bus.req_addr = a7; bus.req_op = FlashOpRead;
    #1 check("hold_gnt0", 32'(bus.gnt), 32'd1);
    @(negedge clk);
    check("hold_gnt_lookup", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    check("hold_valid", 32'(bus.rsp_valid), 32'd1);
    check("hold_gnt_resp", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    check("hold_regnt", 32'(bus.gnt), 32'd1);
    check("hold_idle_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    check("hold_valid2", 32'(bus.rsp_valid), 32'd1);

    // Reset during LOOKUP: no response, table and locks cleared.
    @(negedge clk);
    bus.req = 1'b1; bus.req_addr = a7; bus.req_op = FlashOpRead;
    #1 check("rstlk_gnt", 32'(bus.gnt), 32'd1);
    @(negedge clk);
    bus.req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstlk_valid0", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstlk_valid1", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("rstlk_valid2", 32'(bus.rsp_valid), 32'd0);
    lookup("rstlk_cleared", a7, FlashOpRead, 1'b0, 1'b0, '0);
    cfg_write("rstlk_unlock", a3, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/flash_ctrl_info_priv_chk.md
Name: flash_ctrl_info_priv_chk

Overview:
Registered, parametrised successor to the combinational info-page privilege masking. It holds per-page info configurations for all banks and info types, with per-page lock bits. Seed and isolation privileges are revocable and sticky. Page-access lookups go through a req/gnt/rsp handshake and return the effective masked configuration plus an allow/deny verdict. It sits between the flash_ctrl register file and the flash_ctrl_phy request path.

Parameters:
NumBanks, 2, number of flash banks (BankW = $clog2(NumBanks), minimum 1).
NumInfoTypes, 3, info partitions per bank (InfoTypesWidth bits of sel).
InfosPerBank, 10, maximum pages per info type; valid pages per type come from package InfoTypeSize[].
SeedBank, 0, bank holding the creator/owner seed pages.
SeedInfoSel, 0, info type holding the seed pages.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cfg_we_i  in  1  config write strobe
cfg_lock_i  in  1  with cfg_we_i, set the lock bit of the addressed page (write data is still applied)
cfg_addr_i  in  page_addr_t  page addressed by config write
cfg_wdata_i  in  info_page_cfg_t  config data
cfg_wr_err_o  out  1  one-cycle pulse: write to a locked or out-of-range page
creator_seed_priv_i  in  1  creator seed privilege
owner_seed_priv_i  in  1  owner seed privilege
iso_flash_rd_en_i  in  1  isolated page read privilege
iso_flash_wr_en_i  in  1  isolated page program/erase privilege
req_i  in  1  lookup request
req_addr_i  in  page_addr_t  page to check
req_op_i  in  flash_op_e  FlashOpRead/FlashOpProgram/FlashOpErase
gnt_o  out  1  request accepted
rsp_valid_o  out  1  response valid, one cycle
rsp_allow_o  out  1  operation permitted
rsp_err_o  out  1  out-of-range page
rsp_cfg_o  out  info_page_cfg_t  effective masked configuration

Behaviour:
- Reset: all cfg table entries '0, all lock bits 0, privilege registers 0, FSM IDLE. gnt_o, rsp_valid_o, rsp_allow_o, rsp_err_o and cfg_wr_err_o are 0; rsp_cfg_o is '0.
- Table: NumBanks x NumInfoTypes x InfosPerBank entries. A page is out of range if bank >= NumBanks, sel >= NumInfoTypes, or page index >= InfoTypeSize[sel] (strict; index == size is invalid).
- Config write:
  - In range and unlocked: the entry updates on the next edge. A set cfg_lock_i also sets the lock bit.
  - Locked or out of range: no update; cfg_wr_err_o = 1 next cycle.
  - Locks clear only on reset.
- Privileges: each is held in a register priv_q <= priv_q & priv_i once armed.
  - The arm flag sets at the first cycle after reset where the input is 1.
  - Until armed, priv_q follows the input. After a 1->0 transition the privilege stays 0 until reset (sticky revoke).
- Masking, applied to the stored cfg:
  - Creator seed page (SeedInfoPageSel[CreatorSeedIdx] in SeedBank/SeedInfoSel): AND all bits with creator priv_q.
  - Owner seed page: AND all bits with owner priv_q.
  - IsolatedPageSel: AND with {en 1, rd_en iso_rd, prog_en iso_wr, erase_en iso_wr, scramble_en 1, ecc_en 1, he_en 1}.
  - Other pages: passthrough. Out of range: '0.
- Verdict: allow = en && (read ? rd_en : program ? prog_en : erase_en), evaluated on the masked cfg. Out of range gives allow 0, err 1.
- FSM:
  - IDLE: gnt_o = req_i (combinational). On req_i, capture addr/op and go to LOOKUP.
  - LOOKUP: read the entry and privileges into a pipeline register, go to RESP.
  - RESP: drive rsp_valid_o = 1 with the results, go to IDLE.
  - Fixed latency: rsp_valid_o is 2 cycles after the gnt cycle. gnt_o is 0 in LOOKUP/RESP, so back-to-back grants are 3 cycles apart.
- Same-cycle config write and LOOKUP on the same page: the lookup sees the pre-write value. The write still takes effect.
- Privilege revoke during LOOKUP: the value sampled in LOOKUP is used.
- Reset mid-lookup: the FSM returns to IDLE and no response is emitted.
- req_i held across RESP is re-granted in the IDLE cycle after.

Decomposition:
- flash_ctrl_pkg holds:
  - page_addr_t, info_page_cfg_t, flash_op_e.
  - InfoTypeSize[], SeedInfoPageSel[], CreatorSeedIdx, OwnerSeedIdx, IsolatedPageSel.
  - A new function info_cfg_mask(cfg, addr, privs) returning the masked cfg. It is shared with any remaining combinational users.
- One sub-module, flash_ctrl_sticky_priv, is instantiated four times. It implements the arm/sticky-revoke register.

Test Plan:
- Reset, write page (bank0, sel0, pg3) cfg = all-ones, read request -> rsp_valid 2 cycles after gnt, allow 1, rsp_cfg all-ones.
- Write with cfg_lock_i = 1, then write '0 to the same page -> cfg_wr_err_o pulse; lookup still returns all-ones.
- Creator priv 1 then 0, then 1 again; creator seed page cfg all-ones -> lookup gives rsp_cfg '0 and allow 0 for read/program/erase.
- Isolated page all-ones, iso_rd = 1, iso_wr = 0 -> read allow 1; program and erase allow 0; rsp_cfg prog_en = erase_en = 0.
- req_addr page index == InfoTypeSize[sel] -> rsp_err 1, allow 0, cfg '0. A config write to that index -> cfg_wr_err_o pulse.
- Config write on the same cycle as LOOKUP to the same page (old '0, new all-ones) -> response '0; the next lookup returns all-ones. Assert rst_i during LOOKUP -> no rsp_valid_o.
